rvfi_signature_monitor: RTL and testbench

- Synthesizable, parametrised monitor for the RV32I core's RVFI retirement stream.
- Captures stores to a signature address into a FIFO and drains them over a valid/ready port.
- Detects the halt store (HALT_ADDR/HALT_VALUE) and flags timeout and hang conditions.
- Supports NRET retirement channels per cycle so the same compliance flow runs on wider cores; replaces the behavioural signature/halt logic in the datapath bench.

---
 rtl/rvfi_mon_pkg.sv | 24 ++
 rtl/rvfi_mon_if.sv | 23 ++
 rtl/sig_fifo_mw.sv | 53 +++++
 rtl/rvfi_signature_monitor.sv | 160 ++++++++++++++++
 tb/tb_rvfi_signature_monitor.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvfi_mon_pkg.sv
// Shared types and helpers for the RVFI signature/halt monitor.
// Covers the FSM state encoding, fail codes and store-mask decoding.
package rvfi_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } mon_state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_HANG    = 2'd2;

  function automatic logic wmask_match(input logic [3:0] wmask, input logic full_word_only);
    return full_word_only ? (wmask == 4'b1111) : (wmask != 4'b0000);
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
    return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  endfunction

endpackage

// File: rtl/rvfi_mon_if.sv
// RVFI retirement bundle plus the signature drain handshake.
// The master modport is the core/consumer side; slave is the monitor.
interface rvfi_mon_if #(
  parameter int NRET = 1
);
  logic [NRET-1:0]    rvfi_valid;
  logic [NRET*32-1:0] rvfi_mem_addr;
  logic [NRET*4-1:0]  rvfi_mem_wmask;
  logic [NRET*32-1:0] rvfi_mem_wdata;
  logic               sig_valid;
  logic               sig_ready;
  logic [31:0]        sig_data;

  modport master (
    output rvfi_valid, rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata, sig_ready,
    input  sig_valid, sig_data
  );

  modport slave (
    input  rvfi_valid, rvfi_mem_addr, rvfi_mem_wmask, rvfi_mem_wdata, sig_ready,
    output sig_valid, sig_data
  );
endinterface

// File: rtl/sig_fifo_mw.sv
// Signature FIFO: up to NRET compacted writes per cycle, one read port.
// The caller must never request more pushes than free_cnt reports.
module sig_fifo_mw #(
  parameter int DEPTH = 16,
  parameter int NRET  = 1,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(NRET + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PW-1:0]          push_cnt,
  input  logic [NRET-1:0][W-1:0] push_data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [W-1:0]           rd_data,
  output logic                   pop,
  output logic [CW-1:0]          free_cnt,
  output logic [CW-1:0]          occupancy
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign rd_valid  = (count != '0);
  assign pop       = rd_valid & rd_ready;
  // Head reads as zero when empty, so storage itself needs no reset.
  assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
  assign free_cnt  = CW'(DEPTH) - count + CW'(pop);
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NRET; k++) begin
      if (k < int'(push_cnt)) mem[wr_ptr + AW'(k)] <= push_data[k];
    end
  end

endmodule

// File: rtl/rvfi_signature_monitor.sv
// Watches the RVFI retirement stream: captures signature stores into a FIFO,
// detects the halt store and flags timeout/hang conditions.
module rvfi_signature_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int          NRET           = 1,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] SIG_ADDR       = 32'h8004,
  parameter logic [31:0] HALT_ADDR      = 32'h8008,
  parameter logic [31:0] HALT_VALUE     = 32'hCAFECAFE,
  parameter int          FULL_WORD_ONLY = 1,
  parameter int          TIMEOUT_CYCLES = 900000,
  parameter int          HANG_CYCLES    = 0,
  parameter int          CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  rvfi_mon_if.slave        bus,
  output logic [15:0]      sig_count,
  output logic [CNT_W-1:0] insn_count,
  output logic [1:0]       state,
  output logic             done,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic             overflow
);

  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int PW        = $clog2(NRET + 1);
  localparam int HANG_LAST = (HANG_CYCLES > 0) ? HANG_CYCLES - 1 : 0;

  mon_state_e              st, st_nxt;
  logic [1:0]              fc_nxt;
  logic [CNT_W-1:0]        cycle_cnt, idle_cnt;
  logic [NRET-1:0][31:0]   ch_data;
  logic [NRET-1:0]         sig_hit, halt_hit, live;
  logic [NRET-1:0][31:0]   push_data;
  logic [PW-1:0]           push_cnt;
  logic                    drop;
  logic                    in_run, halt_any, any_valid, timeout_hit, hang_hit;
  logic                    fifo_valid, pop;
  logic [31:0]             fifo_data;
  logic [CW-1:0]           free_cnt, occ;

  assign in_run    = (st == ST_RUN);
  assign any_valid = |bus.rvfi_valid;
  assign halt_any  = |halt_hit;

  // Channel decode; everything above the oldest halt hit is treated as never retired.
  always_comb begin
    logic seen_halt;
    logic ok;
    seen_halt = 1'b0;
    ok        = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      ch_data[i]  = bus.rvfi_mem_wdata[32*i +: 32] & byte_mask(bus.rvfi_mem_wmask[4*i +: 4]);
      ok          = bus.rvfi_valid[i] && wmask_match(bus.rvfi_mem_wmask[4*i +: 4], FULL_WORD_ONLY != 0);
      sig_hit[i]  = ok && (bus.rvfi_mem_addr[32*i +: 32] == SIG_ADDR);
      halt_hit[i] = ok && (bus.rvfi_mem_addr[32*i +: 32] == HALT_ADDR) && (ch_data[i] == HALT_VALUE);
      live[i]     = !seen_halt;
      seen_halt   = seen_halt | halt_hit[i];
    end
  end

  // Compact accepted hits into consecutive write slots, dropping what does not fit.
  always_comb begin
    push_data = '0;
    push_cnt  = '0;
    drop      = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (in_run && live[i] && sig_hit[i]) begin
        if (CW'(push_cnt) < free_cnt) begin
          push_data[push_cnt] = ch_data[i];
          push_cnt            = push_cnt + PW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  sig_fifo_mw #(
    .DEPTH (FIFO_DEPTH),
    .NRET  (NRET),
    .W     (32)
  ) u_fifo (
    .clk       (CLK),
    .rst       (Reset),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .rd_ready  (bus.sig_ready),
    .rd_valid  (fifo_valid),
    .rd_data   (fifo_data),
    .pop       (pop),
    .free_cnt  (free_cnt),
    .occupancy (occ)
  );

  assign bus.sig_valid = fifo_valid;
  assign bus.sig_data  = fifo_data;

  assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign hang_hit    = (HANG_CYCLES != 0) && (idle_cnt == CNT_W'(HANG_LAST)) && !any_valid;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      st        <= ST_RUN;
      fail_code <= FC_NONE;
    end else begin
      st        <= st_nxt;
      fail_code <= fc_nxt;
    end
  end

  // Halt beats timeout beats hang when they coincide.
  always_comb begin
    st_nxt = st;
    fc_nxt = fail_code;
    unique case (st)
      ST_RUN: begin
        if (halt_any) begin
          st_nxt = ST_DRAIN;
        end else if (timeout_hit) begin
          st_nxt = ST_FAIL;
          fc_nxt = FC_TIMEOUT;
        end else if (hang_hit) begin
          st_nxt = ST_FAIL;
          fc_nxt = FC_HANG;
        end
      end
      ST_DRAIN: if (occ == CW'(pop)) st_nxt = ST_DONE;
      default: ;
    endcase
  end

  always_comb begin
    state = st;
    done  = (st == ST_DONE);
    fail  = (st == ST_FAIL);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      sig_count  <= '0;
      insn_count <= '0;
      cycle_cnt  <= '0;
      idle_cnt   <= '0;
      overflow   <= 1'b0;
    end else if (in_run) begin
      logic [16:0] sum;
      sum = {1'b0, sig_count} + 17'(push_cnt);
      sig_count  <= sum[16] ? 16'hFFFF : sum[15:0];
      insn_count <= insn_count + CNT_W'($countones(bus.rvfi_valid & live));
      cycle_cnt  <= cycle_cnt + CNT_W'(1);
      idle_cnt   <= any_valid ? '0 : idle_cnt + CNT_W'(1);
      overflow   <= overflow | drop;
    end
  end

endmodule

// File: tb/tb_rvfi_signature_monitor.sv
// Bench for rvfi_signature_monitor: a 2-channel depth-4 instance (A) and a
// 1-channel partial-mask instance with short timeout/hang limits (B).
module tb_rvfi_signature_monitor;

  localparam logic [31:0] SIG  = 32'h8004;
  localparam logic [31:0] HLT  = 32'h8008;
  localparam logic [31:0] HVAL = 32'hCAFECAFE;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a = 1'b1, rst_b = 1'b1;
  rvfi_mon_if #(.NRET(2)) ifa ();
  rvfi_mon_if #(.NRET(1)) ifb ();

  logic [15:0] cnt_a, cnt_b;
  logic [31:0] insn_a, insn_b;
  logic [1:0]  st_a, st_b, fc_a, fc_b;
  logic        done_a, done_b, fail_a, fail_b, ovf_a, ovf_b;

  rvfi_signature_monitor #(
    .NRET(2), .FIFO_DEPTH(4), .FULL_WORD_ONLY(1), .TIMEOUT_CYCLES(1000), .HANG_CYCLES(0)
  ) dut_a (
    .CLK(CLK), .Reset(rst_a), .bus(ifa), .sig_count(cnt_a), .insn_count(insn_a),
    .state(st_a), .done(done_a), .fail(fail_a), .fail_code(fc_a), .overflow(ovf_a)
  );

  rvfi_signature_monitor #(
    .NRET(1), .FIFO_DEPTH(16), .FULL_WORD_ONLY(0), .TIMEOUT_CYCLES(50), .HANG_CYCLES(8)
  ) dut_b (
    .CLK(CLK), .Reset(rst_b), .bus(ifb), .sig_count(cnt_b), .insn_count(insn_b),
    .state(st_b), .done(done_b), .fail(fail_b), .fail_code(fc_b), .overflow(ovf_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_a(input int ch, input logic v, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    ifa.rvfi_valid[ch]             = v;
    ifa.rvfi_mem_addr[32*ch +: 32] = a;
    ifa.rvfi_mem_wmask[4*ch +: 4]  = m;
    ifa.rvfi_mem_wdata[32*ch +: 32] = d;
  endtask

  task automatic clr_a();
    ifa.rvfi_valid = '0; ifa.rvfi_mem_addr = '0; ifa.rvfi_mem_wmask = '0; ifa.rvfi_mem_wdata = '0;
  endtask

  task automatic set_b(input logic v, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    ifb.rvfi_valid = v; ifb.rvfi_mem_addr = a; ifb.rvfi_mem_wmask = m; ifb.rvfi_mem_wdata = d;
  endtask

  task automatic reset_a();
    rst_a = 1'b1; clr_a(); step(); rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; set_b(1'b0, '0, '0, '0); step(); rst_b = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0, a1;
    logic [3:0]  m0, m1;
    logic [31:0] d0, d1;
    int          e_insn, e_cnt, e_state;
    logic        e_sv;
    logic [31:0] e_sd;
  } vec_t;

  vec_t vt[8];

  // Behavioural reference for instance A: a word queue plus a few counters.
  int unsigned mq[$];
  int          mst, mcyc, mcnt;
  int unsigned minsn;
  bit          movf;

  task automatic model_reset();
    mq.delete(); mst = 0; mcyc = 0; mcnt = 0; minsn = 0; movf = 0;
  endtask

  task automatic run_random(input int cycles);
    logic        v [2];
    logic [31:0] a [2], d [2];
    logic [3:0]  m [2];
    logic        rdy;
    int          nst, r;
    bit          halted;
    reset_a(); model_reset();
    for (int c = 0; c < cycles; c++) begin
      if (mst >= 2 || $urandom_range(0, 79) == 0) begin
        reset_a(); model_reset();
      end
      for (int ch = 0; ch < 2; ch++) begin
        v[ch] = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 99);
        a[ch] = (r < 45) ? SIG : (r < 50) ? HLT : (r < 75) ? 32'h8000 + 32'($urandom_range(0, 3) * 4) : $urandom;
        m[ch] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        d[ch] = (a[ch] == HLT && $urandom_range(0, 1) == 1) ? HVAL : $urandom;
        set_a(ch, v[ch], a[ch], m[ch], d[ch]);
      end
      rdy = 1'($urandom_range(0, 1));
      ifa.sig_ready = rdy;
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      nst = mst;
      if (mst == 0) begin
        halted = 0;
        for (int ch = 0; ch < 2; ch++) begin
          if (!v[ch]) continue;
          minsn++;
          if (m[ch] == 4'hF && a[ch] == HLT && d[ch] == HVAL) begin halted = 1; break; end
          if (m[ch] == 4'hF && a[ch] == SIG) begin
            if (mq.size() < 4) begin mq.push_back(d[ch]); mcnt++; end
            else movf = 1;
          end
        end
        if (halted) nst = 1;
        else if (mcyc == 999) nst = 3;
        mcyc++;
      end else if (mst == 1) begin
        if (mq.size() == 0) nst = 2;
      end
      mst = nst;
      step();
      chk("rnd state", 32'(st_a), mst);
      chk("rnd sig_valid", 32'(ifa.sig_valid), (mq.size() > 0) ? 1 : 0);
      chk("rnd sig_data", ifa.sig_data, (mq.size() > 0) ? mq[0] : 0);
      chk("rnd sig_count", 32'(cnt_a), mcnt);
      chk("rnd insn_count", insn_a, minsn);
      chk("rnd overflow", 32'(ovf_a), 32'(movf));
    end
    ifa.sig_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_a(); ifa.sig_ready = 1'b0;
    set_b(1'b0, '0, '0, '0); ifb.sig_ready = 1'b0;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    chk("reset state", 32'(st_a), 0);
    chk("reset sig_valid", 32'(ifa.sig_valid), 0);
    chk("reset sig_data", ifa.sig_data, 0);
    chk("reset counts", {cnt_a, insn_a[15:0]}, 0);
    chk("reset flags", {28'd0, done_a, fail_a, ovf_a, |fc_a}, 0);

    // Single-channel basic run.
    reset_b(); ifb.sig_ready = 1'b1;
    set_b(1'b1, SIG, 4'hF, 32'h11111111); step();
    chk("basic first word valid", 32'(ifb.sig_valid), 1);
    chk("basic first word", ifb.sig_data, 32'h11111111);
    set_b(1'b1, SIG, 4'hF, 32'h22222222); step();
    chk("basic second word", ifb.sig_data, 32'h22222222);
    set_b(1'b1, HLT, 4'hF, HVAL); step();
    chk("basic drain", 32'(st_b), 1);
    set_b(1'b0, '0, '0, '0); step();
    chk("basic done state", 32'(st_b), 2);
    chk("basic done flag", 32'(done_b), 1);
    chk("basic sig_count", 32'(cnt_b), 2);
    chk("basic insn_count", insn_b, 3);

    // Partial-mask capture zeroes the unwritten bytes.
    reset_b(); ifb.sig_ready = 1'b0;
    set_b(1'b1, SIG, 4'b0011, 32'hDEADBEEF); step();
    set_b(1'b0, '0, '0, '0);
    chk("partial valid", 32'(ifb.sig_valid), 1);
    chk("partial data", ifb.sig_data, 32'h0000BEEF);

    // Timeout lands exactly 50 cycles after reset release.
    reset_b(); set_b(1'b1, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 49; i++) step();
    chk("timeout not yet", 32'(st_b), 0);
    step();
    chk("timeout state", 32'(st_b), 3);
    chk("timeout code", 32'(fc_b), 1);
    chk("timeout fail", 32'(fail_b), 1);
    step(); step(); step();
    chk("timeout sticky", 32'(st_b), 3);
    chk("timeout insn frozen", insn_b, 50);

    // Halt in the timeout cycle wins.
    reset_b(); set_b(1'b1, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 49; i++) step();
    set_b(1'b1, HLT, 4'hF, HVAL); step();
    chk("halt vs timeout", 32'(st_b), 1);
    chk("halt vs timeout fail", 32'(fail_b), 0);

    // Hang on the 8th idle cycle.
    reset_b(); set_b(1'b1, 32'h0, 4'hF, 32'h0);
    step(); step(); step();
    set_b(1'b0, '0, '0, '0);
    for (int i = 0; i < 7; i++) step();
    chk("hang not yet", 32'(st_b), 0);
    step();
    chk("hang state", 32'(st_b), 3);
    chk("hang code", 32'(fc_b), 2);

    // Single-cycle decode table on the 2-channel instance.
    vt[0] = '{2'b11, SIG, HLT, 4'hF, 4'hF, 32'hAAAA0000, HVAL, 2, 1, 1, 1'b1, 32'hAAAA0000};
    vt[1] = '{2'b11, HLT, SIG, 4'hF, 4'hF, HVAL, 32'hBBBB0000, 1, 0, 1, 1'b0, 32'h0};
    vt[2] = '{2'b01, SIG, 32'h0, 4'h3, 4'h0, 32'hDEADBEEF, 32'h0, 1, 0, 0, 1'b0, 32'h0};
    vt[3] = '{2'b11, SIG, SIG, 4'hF, 4'hF, 32'h11111111, 32'h22222222, 2, 2, 0, 1'b1, 32'h11111111};
    vt[4] = '{2'b10, SIG, SIG, 4'hF, 4'hF, 32'h99999999, 32'h33333333, 1, 1, 0, 1'b1, 32'h33333333};
    vt[5] = '{2'b11, HLT, HLT, 4'hF, 4'hF, 32'h12345678, 32'hCAFECAFF, 2, 0, 0, 1'b0, 32'h0};
    vt[6] = '{2'b11, 32'h9000, HLT, 4'hF, 4'hF, 32'h0, HVAL, 2, 0, 1, 1'b0, 32'h0};
    vt[7] = '{2'b11, HLT, SIG, 4'h7, 4'hF, HVAL, 32'h44444444, 2, 1, 0, 1'b1, 32'h44444444};
    ifa.sig_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reset_a();
      set_a(0, vt[i].v[0], vt[i].a0, vt[i].m0, vt[i].d0);
      set_a(1, vt[i].v[1], vt[i].a1, vt[i].m1, vt[i].d1);
      step(); clr_a();
      chk($sformatf("vec%0d state", i), 32'(st_a), vt[i].e_state);
      chk($sformatf("vec%0d insn", i), insn_a, vt[i].e_insn);
      chk($sformatf("vec%0d sig_count", i), 32'(cnt_a), vt[i].e_cnt);
      chk($sformatf("vec%0d sig_valid", i), 32'(ifa.sig_valid), 32'(vt[i].e_sv));
      chk($sformatf("vec%0d sig_data", i), ifa.sig_data, vt[i].e_sd);
    end

    // Overflow with the consumer stalled.
    reset_a(); ifa.sig_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_a(0, 1'b1, SIG, 4'hF, 32'h100 + 32'(k)); step();
    end
    clr_a();
    chk("ovf flag", 32'(ovf_a), 1);
    chk("ovf sig_count", 32'(cnt_a), 4);
    chk("ovf head", ifa.sig_data, 32'h100);

    // A pop in the same cycle frees the slot for the 5th word.
    reset_a();
    for (int k = 0; k < 4; k++) begin
      set_a(0, 1'b1, SIG, 4'hF, 32'h100 + 32'(k)); step();
    end
    set_a(0, 1'b1, SIG, 4'hF, 32'h104); ifa.sig_ready = 1'b1; step();
    clr_a(); ifa.sig_ready = 1'b0;
    chk("push-pop sig_count", 32'(cnt_a), 5);
    chk("push-pop overflow", 32'(ovf_a), 0);
    chk("push-pop head", ifa.sig_data, 32'h101);

    // Reset while draining three queued words.
    reset_a();
    for (int k = 0; k < 3; k++) begin
      set_a(0, 1'b1, SIG, 4'hF, 32'h200 + 32'(k)); step();
    end
    set_a(0, 1'b1, HLT, 4'hF, HVAL); step(); clr_a();
    chk("mid-drain state", 32'(st_a), 1);
    rst_a = 1'b1; step(); rst_a = 1'b0;
    chk("post-reset state", 32'(st_a), 0);
    chk("post-reset sig_valid", 32'(ifa.sig_valid), 0);
    chk("post-reset sig_data", ifa.sig_data, 0);
    chk("post-reset counts", {cnt_a, insn_a[15:0]}, 0);
    chk("post-reset overflow", 32'(ovf_a), 0);

    run_random(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
